// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO: read-mode selectors,
// output-source select encoding and a ceiling-log2 helper.
package sync_fifo_pkg;

    localparam int STD_MODE  = 0;
    localparam int FWFT_MODE = 1;

    // Source of data_out: the held register (reset value, bypassed write,
    // or frozen word) or the RAM read register.
    typedef enum logic {
        SEL_HOLD = 1'b0,
        SEL_RAM  = 1'b1
    } out_sel_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Contents are never reset so the array maps onto block RAM.
module bram_sdp #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value while rd_en is low
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// true full (all DEPTH words usable), programmable almost flags,
// overflow/underflow pulses and a synchronous flush.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_BITS  = 10,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = (2**ADDR_BITS) - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_BITS:0]    usedw,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int FIFO_DEPTH = 2**ADDR_BITS;
    localparam int PTR_W      = clog2(FIFO_DEPTH) + 1;
    localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] AF_LIM    = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_LIM    = PTR_W'(AE_THRESH);

    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_next, rd_ptr_next, usedw_next;
    logic             full_reg, almost_full_reg, empty_reg, almost_empty_reg;
    logic             overflow_reg, underflow_reg;
    logic             req_live, wr_ok, rd_ok;

    logic                  ram_rd_en;
    logic [ADDR_BITS-1:0]  ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] hold_reg;
    out_sel_t              sel_reg;

    // A flush masks every request in its cycle, including error detection.
    assign req_live    = en & ~clr;
    assign wr_ok       = req_live & wr_req & ~full_reg;
    assign rd_ok       = req_live & rd_req & ~empty_reg;
    assign wr_ptr_next = wr_ptr_reg + PTR_W'(wr_ok);
    assign rd_ptr_next = rd_ptr_reg + PTR_W'(rd_ok);
    assign usedw_next  = wr_ptr_next - rd_ptr_next;

    // Pointers, occupancy flags and error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            full_reg         <= 1'b0;
            almost_full_reg  <= 1'b0;
            empty_reg        <= 1'b1;
            almost_empty_reg <= 1'b1;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else if (clr) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            full_reg         <= 1'b0;
            almost_full_reg  <= 1'b0;
            empty_reg        <= 1'b1;
            almost_empty_reg <= 1'b1;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else begin
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            full_reg         <= (usedw_next == DEPTH_CNT);
            almost_full_reg  <= (usedw_next >= AF_LIM);
            empty_reg        <= (usedw_next == '0);
            almost_empty_reg <= (usedw_next <= AE_LIM);
            overflow_reg     <= req_live & wr_req & full_reg;
            underflow_reg    <= req_live & rd_req & empty_reg;
        end
    end

    bram_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr_reg[ADDR_BITS-1:0]),
        .wr_data (data_in),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_q)
    );

    generate
        if (FWFT == FWFT_MODE) begin : g_fwft
            // The RAM continuously prefetches the word that will be head
            // after this edge, so a pop exposes the next word without a bubble.
            assign ram_rd_en   = 1'b1;
            assign ram_rd_addr = rd_ptr_next[ADDR_BITS-1:0];
            assign valid       = ~empty_reg;

            // Choose the head source: bypass a word written straight into
            // the head slot, freeze data_out when nothing is stored.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_reg <= '0;
                    sel_reg  <= SEL_HOLD;
                end else if (clr || (usedw_next == '0)) begin
                    hold_reg <= data_out;
                    sel_reg  <= SEL_HOLD;
                end else if (wr_ok && (rd_ptr_next == wr_ptr_reg)) begin
                    hold_reg <= data_in;
                    sel_reg  <= SEL_HOLD;
                end else begin
                    sel_reg  <= SEL_RAM;
                end
            end
        end else begin : g_std
            logic valid_reg;

            assign ram_rd_en   = rd_ok;
            assign ram_rd_addr = rd_ptr_reg[ADDR_BITS-1:0];
            assign hold_reg    = '0;
            assign valid       = valid_reg;

            // data_out reads as zero until the first accepted read
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sel_reg <= SEL_HOLD;
                end else if (rd_ok) begin
                    sel_reg <= SEL_RAM;
                end
            end

            // valid marks the cycle after an accepted read
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= rd_ok;
                end
            end
        end
    endgenerate

    assign data_out     = (sel_reg == SEL_RAM) ? ram_q : hold_reg;
    assign usedw        = wr_ptr_reg - rd_ptr_reg;
    assign full         = full_reg;
    assign almost_full  = almost_full_reg;
    assign empty        = empty_reg;
    assign almost_empty = almost_empty_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: one standard-mode and one FWFT-mode instance share
// stimulus; a queue-based model predicts count, flags, pulses and data.
module tb_sync_fifo;

    logic        clk = 1'b0;
    logic        rst_n, en, clr, wr_req, rd_req;
    logic [15:0] data_in;

    logic [15:0] s_dout, f_dout;
    logic        s_valid, s_full, s_af, s_empty, s_ae, s_ov, s_un;
    logic        f_valid, f_full, f_af, f_empty, f_ae, f_ov, f_un;
    logic [4:0]  s_usedw, f_usedw;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [15:0] q[$];
    logic [15:0] m_dout;
    bit          m_valid, m_ov, m_un;

    always #5 clk = ~clk;

    sync_fifo #(.DATA_WIDTH(16), .ADDR_BITS(4), .FWFT(0), .AF_THRESH(12), .AE_THRESH(4)) dut_std (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .wr_req(wr_req), .data_in(data_in),
        .rd_req(rd_req), .data_out(s_dout), .valid(s_valid), .full(s_full),
        .almost_full(s_af), .empty(s_empty), .almost_empty(s_ae), .usedw(s_usedw),
        .overflow(s_ov), .underflow(s_un));

    sync_fifo #(.DATA_WIDTH(16), .ADDR_BITS(4), .FWFT(1), .AF_THRESH(12), .AE_THRESH(4)) dut_fwft (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .wr_req(wr_req), .data_in(data_in),
        .rd_req(rd_req), .data_out(f_dout), .valid(f_valid), .full(f_full),
        .almost_full(f_af), .empty(f_empty), .almost_empty(f_ae), .usedw(f_usedw),
        .overflow(f_ov), .underflow(f_un));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare both instances against the model.
    task automatic check_all();
        int sz;
        sz = q.size();
        chk("std_usedw", 32'(s_usedw), 32'(sz));
        chk("std_full", 32'(s_full), 32'(sz == 16));
        chk("std_almost_full", 32'(s_af), 32'(sz >= 12));
        chk("std_empty", 32'(s_empty), 32'(sz == 0));
        chk("std_almost_empty", 32'(s_ae), 32'(sz <= 4));
        chk("std_overflow", 32'(s_ov), 32'(m_ov));
        chk("std_underflow", 32'(s_un), 32'(m_un));
        chk("std_valid", 32'(s_valid), 32'(m_valid));
        chk("std_data_out", 32'(s_dout), 32'(m_dout));
        chk("fwft_usedw", 32'(f_usedw), 32'(sz));
        chk("fwft_flags", {28'd0, f_full, f_af, f_empty, f_ae},
            {28'd0, sz == 16, sz >= 12, sz == 0, sz <= 4});
        chk("fwft_pulses", {30'd0, f_ov, f_un}, {30'd0, m_ov, m_un});
        chk("fwft_valid", 32'(f_valid), 32'(sz != 0));
        if (sz != 0) chk("fwft_data_out", 32'(f_dout), 32'(q[0]));
    endtask

    // One clock of stimulus, model update and comparison.
    task automatic step(input bit i_en, input bit i_clr, input bit i_wr, input bit i_rd,
                        input logic [15:0] i_d);
        bit full_m, empty_m;
        en = i_en; clr = i_clr; wr_req = i_wr; rd_req = i_rd; data_in = i_d;
        @(posedge clk);
        full_m  = (q.size() == 16);
        empty_m = (q.size() == 0);
        m_valid = 1'b0;
        m_ov    = 1'b0;
        m_un    = 1'b0;
        if (i_clr) begin
            q.delete();
        end else if (i_en) begin
            m_ov = i_wr && full_m;
            m_un = i_rd && empty_m;
            if (i_rd && !empty_m) begin
                m_dout  = q.pop_front();
                m_valid = 1'b1;
            end
            if (i_wr && !full_m) q.push_back(i_d);
        end
        #1;
        check_all();
        $display("t=%0t en=%0b clr=%0b wr=%0b rd=%0b din=%h usedw=%0d std_dout=%h fwft_dout=%h ov=%0b un=%0b",
                 $time, i_en, i_clr, i_wr, i_rd, i_d, s_usedw, s_dout, f_dout, s_ov, s_un);
    endtask

    typedef struct {
        bit          en, clr, wr, rd;
        logic [15:0] din;
        int          usedw;
        bit          full, empty, ov, un, valid;
        logic [15:0] dout;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // table of short corner cases, starting from an empty FIFO
        vecs[0] = '{1, 0, 1, 1, 16'h0011, 1, 0, 0, 0, 1, 0, 16'h0000}; // empty rd+wr
        vecs[1] = '{0, 0, 1, 0, 16'h0022, 1, 0, 0, 0, 0, 0, 16'h0000}; // en=0 write
        vecs[2] = '{1, 0, 1, 0, 16'h0033, 2, 0, 0, 0, 0, 0, 16'h0000};
        vecs[3] = '{1, 0, 0, 1, 16'h0000, 1, 0, 0, 0, 0, 1, 16'h0011};
        vecs[4] = '{1, 0, 0, 1, 16'h0000, 0, 0, 1, 0, 0, 1, 16'h0033};
        vecs[5] = '{1, 0, 0, 1, 16'h0000, 0, 0, 1, 0, 1, 0, 16'h0033}; // underflow
        vecs[6] = '{1, 1, 1, 1, 16'h0055, 0, 0, 1, 0, 0, 0, 16'h0033}; // clr masks
        vecs[7] = '{1, 0, 1, 0, 16'h0044, 1, 0, 0, 0, 0, 0, 16'h0033};

        rst_n = 1'b0; en = 1'b0; clr = 1'b0; wr_req = 1'b0; rd_req = 1'b0; data_in = '0;
        q.delete(); m_dout = '0; m_valid = 0; m_ov = 0; m_un = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_fwft_data_out", 32'(f_dout), 32'h0);
        #2 rst_n = 1'b1;

        // table-driven vectors
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].en, vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].din);
            chk("tbl_usedw", 32'(s_usedw), 32'(vecs[i].usedw));
            chk("tbl_flags", {28'd0, s_full, s_empty, s_ov, s_un},
                {28'd0, vecs[i].full, vecs[i].empty, vecs[i].ov, vecs[i].un});
            chk("tbl_valid", 32'(s_valid), 32'(vecs[i].valid));
            chk("tbl_dout", 32'(s_dout), 32'(vecs[i].dout));
        end

        // fill to full, overflow, full rd+wr, drain
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 0, 1, 0, 16'(i));
        chk("fill_full", {27'd0, s_full, s_usedw}, {27'd0, 1'b1, 5'd16});
        step(1, 0, 1, 0, 16'h0BAD);
        chk("ovf_pulse", {27'd0, s_ov, s_usedw}, {27'd0, 1'b1, 5'd16});
        step(0, 0, 1, 0, 16'h0BAD);
        chk("en0_no_ovf", {27'd0, s_ov, s_usedw}, {27'd0, 1'b0, 5'd16});
        step(1, 0, 1, 1, 16'h0099);
        chk("full_rdwr", {27'd0, s_ov, s_usedw}, {27'd0, 1'b1, 5'd15});
        chk("full_rdwr_dout", 32'(s_dout), 32'h0);
        for (int i = 0; i < 15; i++) step(1, 0, 0, 1, 0);
        chk("drain_empty", {31'd0, s_empty}, 32'd1);

        // FWFT fall-through and back-to-back pops
        step(1, 0, 1, 0, 16'hA5A5);
        chk("fwft_fallthrough", {15'd0, f_empty, f_dout}, {15'd0, 1'b0, 16'hA5A5});
        step(1, 0, 1, 0, 16'hB1B1);
        step(1, 0, 1, 0, 16'hC2C2);
        step(1, 0, 1, 1, 16'hD3D3);
        chk("fwft_pop1", 32'(f_dout), 32'hB1B1);
        step(1, 0, 0, 1, 0);
        chk("fwft_pop2", 32'(f_dout), 32'hC2C2);
        step(1, 0, 0, 1, 0);
        chk("fwft_pop3", 32'(f_dout), 32'hD3D3);
        step(1, 0, 0, 1, 0);

        // wrap with simultaneous read and write at usedw=5
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 16'(16'h100 + i));
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 1, 1, 16'(16'h200 + i));
            chk("wrap_usedw", 32'(s_usedw), 32'd5);
        end

        // flush with 9 words stored and requests asserted
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(1, 0, 1, 0, 16'(16'h300 + i));
        step(1, 1, 1, 1, 16'hEEEE);
        chk("clr_result", {25'd0, s_empty, s_ov, s_un, s_usedw}, {25'd0, 1'b1, 1'b0, 1'b0, 5'd0});

        // randomized traffic with varying write bias
        for (int ph = 0; ph < 4; ph++) begin
            int pw;
            pw = 20 + ph * 20;
            for (int i = 0; i < 100; i++) begin
                step($urandom_range(0, 99) < 92, $urandom_range(0, 99) < 3,
                     $urandom_range(0, 99) < pw, $urandom_range(0, 99) < 50,
                     16'($urandom));
            end
        end

        // asynchronous reset mid-stream while an overflow pulse is high
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 0, 1, 0, 16'(16'h400 + i));
        step(1, 0, 0, 1, 0);
        step(1, 0, 1, 0, 16'h0777);
        step(1, 0, 1, 0, 16'h0888);
        #2 rst_n = 1'b0;
        #1;
        q.delete(); m_dout = '0; m_valid = 0; m_ov = 0; m_un = 0;
        check_all();
        chk("async_rst_fwft_dout", 32'(f_dout), 32'h0);
        #2 rst_n = 1'b1;
        step(1, 0, 1, 0, 16'h1234);
        step(1, 0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
